// File: rtl/board_pkg.sv
// Shared constants, op codes and FSM state encoding for the board map controller.
package board_pkg;

  localparam int unsigned ROWS   = 8;
  localparam int unsigned COLS   = 18;
  localparam int unsigned CELLS  = ROWS * COLS;
  localparam int unsigned CARD_W = 6;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned MAP_W  = CELLS * CARD_W;

  localparam logic [CARD_W-1:0] CARD_EMPTY = '0;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_MOVE  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_code_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CLEAR,
    DONE
  } state_e;

endpackage

// File: rtl/board_addr_calc.sv
// Combinational row/col to linear cell index, with out-of-range flag.
module board_addr_calc
  import board_pkg::*;
(
  input  logic [2:0]       row,
  input  logic [4:0]       col,
  output logic [IDX_W-1:0] idx,
  output logic             oor
);

  always_comb begin
    idx = IDX_W'({5'b0, row} * IDX_W'(COLS)) + IDX_W'(col);
    oor = ({1'b0, row} >= 4'(ROWS)) || ({1'b0, col} >= 6'(COLS));
  end

endmodule

// File: rtl/board_map_ctrl.sv
// Board map controller: WRITE/MOVE/CLEAR over valid/ready, live card count.
// Optional MAP_VSYNC_COMMIT_EN: map becomes a shadow copy committed on frame_start.
module board_map_ctrl
  import board_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [1:0]          op_code,
  input  logic [2:0]          dst_row,
  input  logic [4:0]          dst_col,
  input  logic [2:0]          src_row,
  input  logic [4:0]          src_col,
  input  logic [CARD_W-1:0]   wr_card,
  output logic                done,
  output logic                err,
  output logic [7:0]          card_count,
  input  logic                frame_start,
  output logic [MAP_W-1:0]    map
);

  state_e             state;
  op_code_e           op_q;
  logic [2:0]         dst_row_q, src_row_q;
  logic [4:0]         dst_col_q, src_col_q;
  logic [CARD_W-1:0]  card_q;
  logic [IDX_W-1:0]   sweep_idx;
  logic [CARD_W-1:0]  cells [CELLS];

  logic [IDX_W-1:0]   dst_idx, src_idx;
  logic               dst_oor, src_oor;
  logic [CARD_W-1:0]  dst_card, src_card;
  logic               move_bad;
  logic [MAP_W-1:0]   board_flat;

  board_addr_calc u_dst_addr (
    .row (dst_row_q),
    .col (dst_col_q),
    .idx (dst_idx),
    .oor (dst_oor)
  );

  board_addr_calc u_src_addr (
    .row (src_row_q),
    .col (src_col_q),
    .idx (src_idx),
    .oor (src_oor)
  );

  always_comb begin
    dst_card = dst_oor ? CARD_EMPTY : cells[dst_idx];
    src_card = src_oor ? CARD_EMPTY : cells[src_idx];
    move_bad = src_oor || dst_oor || (src_card == CARD_EMPTY) ||
               (dst_card != CARD_EMPTY) || (src_idx == dst_idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op_ready   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      card_count <= '0;
      op_q       <= OP_WRITE;
      dst_row_q  <= '0;
      dst_col_q  <= '0;
      src_row_q  <= '0;
      src_col_q  <= '0;
      card_q     <= '0;
      sweep_idx  <= '0;
      for (int unsigned i = 0; i < CELLS; i++) cells[i] <= CARD_EMPTY;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid && op_ready) begin
            op_q      <= op_code_e'(op_code);
            dst_row_q <= dst_row;
            dst_col_q <= dst_col;
            src_row_q <= src_row;
            src_col_q <= src_col;
            card_q    <= wr_card;
            sweep_idx <= '0;
            op_ready  <= 1'b0;
            state     <= (op_code_e'(op_code) == OP_CLEAR) ? CLEAR : EXEC;
          end
        end
        EXEC: begin
          state <= DONE;
          done  <= 1'b1;
          case (op_q)
            OP_WRITE: begin
              if (dst_oor) begin
                err <= 1'b1;
              end else begin
                cells[dst_idx] <= card_q;
                if (dst_card == CARD_EMPTY && card_q != CARD_EMPTY)
                  card_count <= card_count + 8'd1;
                else if (dst_card != CARD_EMPTY && card_q == CARD_EMPTY)
                  card_count <= card_count - 8'd1;
              end
            end
            OP_MOVE: begin
              if (move_bad) begin
                err <= 1'b1;
              end else begin
                cells[dst_idx] <= src_card;
                cells[src_idx] <= CARD_EMPTY;
              end
            end
            default: err <= 1'b1;
          endcase
        end
        CLEAR: begin
          // Sweep runs 0..143, then one extra edge at 144 to enter DONE.
          if (sweep_idx == IDX_W'(CELLS)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            cells[sweep_idx] <= CARD_EMPTY;
            if (sweep_idx == IDX_W'(CELLS - 1)) card_count <= '0;
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    board_flat = '0;
    for (int unsigned i = 0; i < CELLS; i++)
      board_flat[i*CARD_W +: CARD_W] = cells[i];
  end

`ifdef MAP_VSYNC_COMMIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      map <= '0;
    else if (frame_start)
      map <= board_flat;
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign map = board_flat;
`endif

endmodule

// File: tb/tb_board_map_ctrl.sv
// Directed bench for board_map_ctrl with a cell-array reference model checked every cycle.
module tb_board_map_ctrl;
  import board_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              op_valid = 1'b0;
  logic [1:0]        op_code = 2'b00;
  logic [2:0]        dst_row = '0, src_row = '0;
  logic [4:0]        dst_col = '0, src_col = '0;
  logic [CARD_W-1:0] wr_card = '0;
  logic              frame_start = 1'b0;
  logic              op_ready, done, err;
  logic [7:0]        card_count;
  logic [MAP_W-1:0]  map;

  always #5 clk = ~clk;

  board_map_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .dst_row     (dst_row),
    .dst_col     (dst_col),
    .src_row     (src_row),
    .src_col     (src_col),
    .wr_card     (wr_card),
    .done        (done),
    .err         (err),
    .card_count  (card_count),
    .frame_start (frame_start),
    .map         (map)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: working board, displayed board, count, handshake expectations.
  int work [CELLS] = '{default: 0};
  int disp [CELLS] = '{default: 0};
  int model_count = 0;
  bit exp_ready = 1'b1, exp_done = 1'b0, exp_err = 1'b0, chk_en = 1'b0;

  // Timing monitor state.
  int cyc = 0, acc_cyc = 0, done_off = -1, low_run = 0, last_low_run = 0, n_done = 0;
  logic last_err = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  function automatic int map_cell(input int i);
    logic [MAP_W-1:0] m;
    m = map;
    return int'(m[i*CARD_W +: CARD_W]);
  endfunction

  function automatic int shown_cell(input int i);
`ifdef MAP_VSYNC_COMMIT_EN
    return disp[i];
`else
    return work[i];
`endif
  endfunction

`ifdef MAP_VSYNC_COMMIT_EN
  always @(posedge clk or negedge rst) begin
    if (!rst) disp <= '{default: 0};
    else if (frame_start) disp <= work;
  end
`endif

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (op_valid && op_ready) acc_cyc = cyc;
  end

  always @(negedge clk) begin
    if (done) begin
      done_off = cyc - acc_cyc;
      last_err = err;
      n_done++;
    end
    if (!op_ready) low_run++;
    else begin
      if (low_run != 0) last_low_run = low_run;
      low_run = 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int bad;
    if (chk_en) begin
      check("op_ready", op_ready, exp_ready);
      check("done", done, exp_done);
      if (exp_done) check("err", err, exp_err);
      check("card_count", card_count, model_count);
      bad = -1;
      for (int i = 0; i < CELLS; i++)
        if (bad < 0 && map_cell(i) != shown_cell(i)) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL map cell %0d: got %0d expected %0d", bad, map_cell(bad), shown_cell(bad));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_apply(input logic [1:0] oc, input int dr, input int dc,
                             input int sr, input int sc, input int card);
    int d, s;
    d = dr * COLS + dc;
    s = sr * COLS + sc;
    exp_err = 1'b0;
    case (oc)
      2'b00: begin
        if (dr >= ROWS || dc >= COLS) exp_err = 1'b1;
        else begin
          if (work[d] == 0 && card != 0) model_count++;
          else if (work[d] != 0 && card == 0) model_count--;
          work[d] = card;
        end
      end
      2'b01: begin
        if (dr >= ROWS || dc >= COLS || sr >= ROWS || sc >= COLS) exp_err = 1'b1;
        else if (work[s] == 0 || work[d] != 0 || s == d) exp_err = 1'b1;
        else begin
          work[d] = work[s];
          work[s] = 0;
        end
      end
      default: exp_err = 1'b1;
    endcase
  endtask

  // Issue one op; with noise, op_valid stays high with junk while busy.
  task automatic do_op(input logic [1:0] oc, input int dr, input int dc,
                       input int sr, input int sc, input int card, input bit noise);
    op_code = oc;
    dst_row = 3'(dr);
    dst_col = 5'(dc);
    src_row = 3'(sr);
    src_col = 5'(sc);
    wr_card = CARD_W'(card);
    op_valid = 1'b1;
    step();
    exp_ready = 1'b0;
    if (noise) begin
      op_code = 2'b00;
      dst_row = '0;
      dst_col = '0;
      wr_card = 6'd63;
    end else begin
      op_valid = 1'b0;
    end
    if (oc == 2'b10) begin
      for (int i = 0; i < CELLS; i++) begin
        step();
        work[i] = 0;
        if (i == CELLS - 1) model_count = 0;
      end
      step();
      exp_err = 1'b0;
    end else begin
      step();
      model_apply(oc, dr, dc, sr, sc, card);
    end
    exp_done = 1'b1;
    step();
    exp_done = 1'b0;
    exp_ready = 1'b1;
    op_valid = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    frame_start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;
    check("reset_ready", op_ready, 1);
    check("reset_done", done, 0);
    check("reset_count", card_count, 0);
    check("reset_map_zero", (map == '0), 1);

    // WRITE (2,5)=13 -> index 41
    do_op(2'b00, 2, 5, 0, 0, 13, 1'b0);
    step();
    check("w41_cell", map[251:246], 13);
    check("w41_done_cycle", done_off + 1, 2);
    check("w41_ready_low", last_low_run, 2);
    check("w41_err", last_err, 0);
    check("w41_count", card_count, 1);

    // MOVE (2,5)->(7,17)
    do_op(2'b01, 7, 17, 2, 5, 0, 1'b0);
    check("mv_dst", map[863:858], 13);
    check("mv_src", map[251:246], 0);
    check("mv_err", last_err, 0);
    check("mv_count", card_count, 1);

    // Rejected moves
    do_op(2'b01, 1, 1, 0, 0, 0, 1'b1);
    check("mv_from_empty_err", last_err, 1);
    do_op(2'b00, 3, 3, 0, 0, 9, 1'b1);
    check("w33_count", card_count, 2);
    do_op(2'b01, 7, 17, 3, 3, 0, 1'b0);
    check("mv_onto_occupied_err", last_err, 1);
    check("mv_onto_occupied_keep", map[863:858], 13);
    do_op(2'b01, 3, 3, 3, 3, 0, 1'b0);
    do_op(2'b01, 1, 1, 3, 20, 0, 1'b0);
    do_op(2'b01, 1, 25, 3, 3, 0, 1'b0);

    // Rejected write and reserved code
    do_op(2'b00, 0, 18, 0, 0, 7, 1'b0);
    check("w_col18_err", last_err, 1);
    do_op(2'b11, 1, 1, 3, 3, 7, 1'b0);
    check("rsvd_err", last_err, 1);
    check("rsvd_count", card_count, 2);

    // Overwrite, erase, erase-empty (back-to-back, with busy noise)
    do_op(2'b00, 3, 3, 0, 0, 20, 1'b1);
    do_op(2'b00, 3, 3, 0, 0, 0, 1'b1);
    do_op(2'b00, 0, 0, 0, 0, 0, 1'b0);
    check("erase_count", card_count, 1);

    // Three cards then CLEAR
    do_op(2'b00, 0, 0, 0, 0, 5, 1'b0);
    do_op(2'b00, 4, 4, 0, 0, 1, 1'b0);
    check("pre_clear_count", card_count, 3);
    do_op(2'b10, 0, 0, 0, 0, 0, 1'b1);
    step();
    check("clr_done_off", done_off, 145);
    check("clr_ready_low", last_low_run, 146);
    check("clr_count", card_count, 0);
    check("clr_map_zero", (map == '0), 1);

    // Reset in the middle of CLEAR
    do_op(2'b00, 5, 9, 0, 0, 33, 1'b0);
    do_op(2'b00, 6, 2, 0, 0, 44, 1'b0);
    op_code = 2'b10;
    op_valid = 1'b1;
    step();
    exp_ready = 1'b0;
    op_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      work[i] = 0;
    end
    n_done = 0;
    #2;
    rst = 1'b0;
    work = '{default: 0};
    model_count = 0;
    exp_ready = 1'b1;
    exp_done = 1'b0;
    #1;
    check("abort_map_zero", (map == '0), 1);
    check("abort_ready", op_ready, 1);
    check("abort_count", card_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) step();
    check("abort_no_done", n_done, 0);

`ifdef MAP_VSYNC_COMMIT_EN
    frame_start = 1'b0;
    do_op(2'b00, 0, 0, 0, 0, 5, 1'b0);
    check("vs_hold", map[5:0], 0);
    repeat (3) step();
    frame_start = 1'b1;
    check("vs_pre_edge", map[5:0], 0);
    step();
    frame_start = 1'b0;
    check("vs_commit", map[5:0], 5);
`else
    frame_start = 1'b0;
    do_op(2'b00, 0, 0, 0, 0, 5, 1'b0);
    check("nofs_direct", map[5:0], 5);
`endif
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
